issue_sched: RTL



---
 rtl/issue_sched_pkg.sv | 26 ++
 rtl/issue_sched_if.sv | 46 ++++
 rtl/issue_sched_sb_counter.sv | 64 ++++++
 rtl/issue_sched.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/issue_sched_pkg.sv
// -----------------------------------------------------------------------------
// issue_sched_pkg
// Shared definitions for the decode-stage issue scheduler:
//   - default register-file geometry (NUM_REGS_DEF, SEL_W_DEF, PEND_W_DEF)
//   - MAX_PEND: largest in-flight write count per register
//   - HALT_OPC: opcode of the HALT instruction
//   - state_t: scheduler FSM states
// No ports.
// -----------------------------------------------------------------------------
package issue_sched_pkg;

  localparam int NUM_REGS_DEF = 8;
  localparam int SEL_W_DEF    = 3;
  localparam int PEND_W_DEF   = 2;
  localparam int MAX_PEND     = (1 << PEND_W_DEF) - 1;

  localparam logic [4:0] HALT_OPC = 5'b00000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BR_WAIT = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } state_t;

endpackage

// File: rtl/issue_sched_if.sv
// -----------------------------------------------------------------------------
// issue_sched_if
// Decode <-> scheduler bundle.
//   master (decode/pipeline side): drives the decoded-instruction fields,
//     writeback retire and branch resolve; receives issue/stall/flush/
//     halted/err.
//   slave (issue_sched): the mirror image.
// Parameter SEL_W: register select width.
// -----------------------------------------------------------------------------
interface issue_sched_if
  import issue_sched_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF
);
  logic             dec_valid;
  logic             rs_use;
  logic [SEL_W-1:0] rs_sel;
  logic             rt_use;
  logic [SEL_W-1:0] rt_sel;
  logic             rd_wr;
  logic [SEL_W-1:0] rd_sel;
  logic             is_brju;
  logic             is_halt;
  logic             wb_valid;
  logic [SEL_W-1:0] wb_sel;
  logic             br_resolve;
  logic             br_taken;

  logic             issue;
  logic             stall;
  logic             flush;
  logic             halted;
  logic             err;

  modport master (
    output dec_valid, rs_use, rs_sel, rt_use, rt_sel, rd_wr, rd_sel,
           is_brju, is_halt, wb_valid, wb_sel, br_resolve, br_taken,
    input  issue, stall, flush, halted, err
  );

  modport slave (
    input  dec_valid, rs_use, rs_sel, rt_use, rt_sel, rd_wr, rd_sel,
           is_brju, is_halt, wb_valid, wb_sel, br_resolve, br_taken,
    output issue, stall, flush, halted, err
  );
endinterface

// File: rtl/issue_sched_sb_counter.sv
// -----------------------------------------------------------------------------
// issue_sched_sb_counter
// One scoreboard entry: saturating up/down count of in-flight writes to a
// single architectural register.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_inc           an issued instruction will write this register
//   i_dec           writeback retires a write to this register
//   o_zero          no writes in flight
//   o_one           exactly one write in flight
//   o_full          count at its maximum (2^PEND_W-1)
//   o_zero_next     count will be zero after this edge
//   o_uflow_err     retire seen with nothing in flight (retire is dropped)
// -----------------------------------------------------------------------------
module issue_sched_sb_counter #(
  parameter int PEND_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_zero,
  output logic o_one,
  output logic o_full,
  output logic o_zero_next,
  output logic o_uflow_err
);

  logic [PEND_W-1:0] r_count;
  logic [PEND_W-1:0] w_count_nxt;
  logic              w_do_inc;
  logic              w_do_dec;

  assign o_zero      = (r_count == '0);
  assign o_one       = (r_count == PEND_W'(1));
  assign o_full      = (r_count == {PEND_W{1'b1}});
  assign o_uflow_err = i_dec & o_zero;

  // A retire on an empty counter is discarded; an increment on a full
  // counter only goes through when a genuine retire makes room.
  assign w_do_dec = i_dec & ~o_zero;
  assign w_do_inc = i_inc & (~o_full | w_do_dec);

  always_comb begin
    // NOTE: default first so every path assigns w_count_nxt; no latch.
    w_count_nxt = r_count;
    if (w_do_inc && !w_do_dec)
      w_count_nxt = r_count + PEND_W'(1);
    else if (w_do_dec && !w_do_inc)
      w_count_nxt = r_count - PEND_W'(1);
  end

  assign o_zero_next = (w_count_nxt == '0);

  always_ff @(posedge clk) begin
    // NOTE: scoreboard state must be reset explicitly; a stale count after
    // reset would stall decode forever. Non-blocking keeps the update atomic.
    if (rst)
      r_count <= '0;
    else
      r_count <= w_count_nxt;
  end

endmodule

// File: rtl/issue_sched.sv
// -----------------------------------------------------------------------------
// issue_sched
// Decode-stage issue scheduler for the 16-bit pipelined core. Tracks
// in-flight register writes, stalls decode on RAW hazards or write-count
// saturation, serialises branches/jumps (flush pulse when taken) and drains
// the pipe on HALT before raising halted.
// Ports:
//   clk   core clock
//   rst   synchronous active-high reset
//   bus   issue_sched_if.slave: decode fields, writeback retire, branch
//         resolve in; issue/stall/flush/halted/err out
// Build option:
//   ISSUE_SCHED_WB_BYPASS_EN  register file forwards the write being retired
//                             to a same-cycle read, so a source whose only
//                             pending write retires this cycle is not a hazard.
// -----------------------------------------------------------------------------
module issue_sched
  import issue_sched_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int SEL_W    = SEL_W_DEF,
  parameter int PEND_W   = PEND_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  issue_sched_if.slave   bus
);

`ifdef ISSUE_SCHED_WB_BYPASS_EN
  localparam bit WB_BYPASS = 1'b1;
`else
  localparam bit WB_BYPASS = 1'b0;
`endif

  state_t r_state;
  state_t w_state_nxt;
  logic   r_err;

  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_dec;
  logic [NUM_REGS-1:0] w_zero;
  logic [NUM_REGS-1:0] w_one;
  logic [NUM_REGS-1:0] w_full;
  logic [NUM_REGS-1:0] w_zero_nxt;
  logic [NUM_REGS-1:0] w_uflow;

  logic w_rs_haz;
  logic w_rt_haz;
  logic w_rd_haz;
  logic w_hazard;
  logic w_issue;
  logic w_stall;
  logic w_flush;
  logic w_halted;
  logic w_err_set;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    assign w_inc[r] = w_issue & bus.rd_wr & (bus.rd_sel == SEL_W'(r));
    assign w_dec[r] = bus.wb_valid & (bus.wb_sel == SEL_W'(r));

    issue_sched_sb_counter #(
      .PEND_W (PEND_W)
    ) u_cnt (
      .clk         (clk),
      .rst         (rst),
      .i_inc       (w_inc[r]),
      .i_dec       (w_dec[r]),
      .o_zero      (w_zero[r]),
      .o_one       (w_one[r]),
      .o_full      (w_full[r]),
      .o_zero_next (w_zero_nxt[r]),
      .o_uflow_err (w_uflow[r])
    );
  end

  // Without bypass the retiring write lands at the edge, so a source read in
  // the same cycle would see the stale value. With bypass, a source whose last
  // pending write is retiring now is forwarded and needs no stall. The
  // destination check is deliberately unaffected.
  assign w_rs_haz = bus.rs_use & ~w_zero[bus.rs_sel] &
                    ~(WB_BYPASS & w_one[bus.rs_sel] & w_dec[bus.rs_sel]);
  assign w_rt_haz = bus.rt_use & ~w_zero[bus.rt_sel] &
                    ~(WB_BYPASS & w_one[bus.rt_sel] & w_dec[bus.rt_sel]);
  assign w_rd_haz = bus.rd_wr & w_full[bus.rd_sel];
  assign w_hazard = w_rs_haz | w_rt_haz | w_rd_haz;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        // Branch wins when both flags are set on one instruction.
        if (w_issue && bus.is_brju)
          w_state_nxt = BR_WAIT;
        else if (w_issue && bus.is_halt)
          w_state_nxt = DRAIN;
      end
      BR_WAIT: begin
        if (bus.br_resolve)
          w_state_nxt = IDLE;
      end
      DRAIN: begin
        // Look at post-update counts so the last retire moves us on at once.
        if (&w_zero_nxt)
          w_state_nxt = HALTED;
      end
      HALTED: w_state_nxt = HALTED;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (reset overrides everything so the pipe holds during rst)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_issue  = ~rst & bus.dec_valid & (r_state == IDLE) & ~w_hazard;
    w_stall  = rst | (bus.dec_valid & ~w_issue);
    w_flush  = ~rst & (r_state == BR_WAIT) & bus.br_resolve & bus.br_taken;
    w_halted = ~rst & (r_state == HALTED);
  end

  // ---------------------------------------------------------------------------
  // Sticky protocol error
  // ---------------------------------------------------------------------------
  assign w_err_set = (|w_uflow)
                   | (bus.br_resolve & (r_state != BR_WAIT))
                   | (w_issue & bus.is_brju & bus.is_halt);

  always_ff @(posedge clk) begin
    if (rst)
      r_err <= 1'b0;
    else if (w_err_set)
      r_err <= 1'b1;
  end

  assign bus.issue  = w_issue;
  assign bus.stall  = w_stall;
  assign bus.flush  = w_flush;
  assign bus.halted = w_halted;
  assign bus.err    = r_err;

endmodule
